// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_conditioner                                              |
// | Description : Push-button conditioner. Synchronises the raw pin, debounces |
// |               it and emits a debounced level, one-cycle press/release      |
// |               strobes and a wrapping press counter. With BTN_LONG_PRESS_EN |
// |               defined, a one-cycle long-press strobe is also produced;     |
// |               otherwise long_pulse is tied low.                            |
// | Ports       : clk_raw       - oscillator clock, rising edge               |
// |               rst_n         - synchronous active-low reset                |
// |               btn_pin       - raw asynchronous button pin                 |
// |               btn_level     - debounced pressed state (1 = pressed)       |
// |               press_pulse   - one-cycle strobe on committed press         |
// |               release_pulse - one-cycle strobe on committed release       |
// |               long_pulse    - one-cycle strobe after a long hold          |
// |               press_count   - committed presses, modulo 2^C_PCNT_W        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_conditioner #(
    parameter int C_DEBOUNCE_CNT = 1_000_000,
    parameter int C_LONG_CNT     = 100_000_000,
    parameter int C_ACTIVE_HIGH  = 1,
    parameter int C_PCNT_W       = 8
) (
    input  logic                clk_raw,
    input  logic                rst_n,
    input  logic                btn_pin,
    output logic                btn_level,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic                long_pulse,
    output logic [C_PCNT_W-1:0] press_count
);

    localparam int               CNT_W    = $clog2(C_DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(C_DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  level_next;
    logic                  press_next;
    logic                  release_next;
    logic [C_PCNT_W-1:0]   count_next;

    logic                  pin_pol;
    logic                  s1;
    logic                  s2;

    // Polarity is normalised before the synchroniser so everything downstream
    // sees 1 = pressed.
    assign pin_pol = (C_ACTIVE_HIGH != 0) ? btn_pin : ~btn_pin;

    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pin_pol;
            s2 <= s1;
        end
    end

    // State, debounce counter and all outputs are registered together.
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= next_state;
            cnt           <= cnt_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            press_count   <= count_next;
        end
    end

    // The WAIT states count agreeing samples; the first one is counted on
    // entry, so a commit needs C_DEBOUNCE_CNT+1 consecutive samples.
    always_comb begin
        next_state   = state;
        cnt_next     = cnt;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        count_next   = press_count;
        case (state)
            ST_RELEASED: begin
                if (s2) begin
                    next_state = ST_PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s2) begin
                    next_state = ST_RELEASED;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    next_state = ST_PRESSED;
                    level_next = 1'b1;
                    press_next = 1'b1;
                    count_next = press_count + C_PCNT_W'(1);
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s2) begin
                    next_state = ST_RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s2) begin
                    next_state = ST_PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    next_state   = ST_RELEASED;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else begin
                    cnt_next     = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = ST_RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(C_LONG_CNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(C_LONG_CNT);

    logic [HOLD_W-1:0] hold_cnt;

    // The timer runs while the debounced level is high (PRESSED or a pending
    // release) and saturates at C_LONG_CNT, so one hold yields one strobe.
    // A bounce back from RELEASE_WAIT to PRESSED keeps the accumulated time.
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if ((next_state == ST_RELEASED) ||
                (state == ST_PRESS_WAIT && next_state == ST_PRESSED)) begin
                hold_cnt <= '0;
            end else if ((state == ST_PRESSED || state == ST_RELEASE_WAIT) &&
                         (hold_cnt != HOLD_LAST)) begin
                hold_cnt   <= hold_cnt + HOLD_W'(1);
                long_pulse <= (hold_cnt == HOLD_LAST - HOLD_W'(1));
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_btn_conditioner                                           |
// | Description : Self-checking bench for btn_conditioner. Two instances run   |
// |               side by side: active-high on btn_pin and active-low on its   |
// |               inverse, so both must behave identically. A run-length       |
// |               reference model supplies every expected output.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int L  = 20;
    localparam int PW = 2;

    logic          clk_raw = 1'b0;
    logic          rst_n   = 1'b0;
    logic          btn_pin = 1'b1;
    logic          btn_pin_n;
    logic          hi_level, hi_press, hi_rel, hi_long;
    logic [PW-1:0] hi_count;
    logic          lo_level, lo_press, lo_rel, lo_long;
    logic [PW-1:0] lo_count;

    int n_vec = 0;
    int n_err = 0;

    assign btn_pin_n = ~btn_pin;

    always #5 clk_raw = ~clk_raw;

    btn_conditioner #(.C_DEBOUNCE_CNT(D), .C_LONG_CNT(L), .C_ACTIVE_HIGH(1), .C_PCNT_W(PW)) dut_hi (
        .clk_raw(clk_raw), .rst_n(rst_n), .btn_pin(btn_pin),
        .btn_level(hi_level), .press_pulse(hi_press), .release_pulse(hi_rel),
        .long_pulse(hi_long), .press_count(hi_count));

    btn_conditioner #(.C_DEBOUNCE_CNT(D), .C_LONG_CNT(L), .C_ACTIVE_HIGH(0), .C_PCNT_W(PW)) dut_lo (
        .clk_raw(clk_raw), .rst_n(rst_n), .btn_pin(btn_pin_n),
        .btn_level(lo_level), .press_pulse(lo_press), .release_pulse(lo_rel),
        .long_pulse(lo_long), .press_count(lo_count));

    // Reference model: the debounced level flips once D+1 consecutive
    // synchronised samples disagree with it; the hold timer counts cycles
    // spent with the level high since the press was committed.
    logic m_s1, m_s2, m_level, m_press, m_rel, m_long;
    int   m_run, m_hold, m_count;

    always @(posedge clk_raw) begin
        logic s, old, commit;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
            m_run = 0; m_hold = 0; m_count = 0;
        end else begin
            s = m_s2; m_s2 = m_s1; m_s1 = btn_pin;
            old = m_level;
            m_press = 0; m_rel = 0; m_long = 0;
            if (s != old) m_run = m_run + 1;
            else          m_run = 0;
            commit = (m_run == D + 1);
            if (commit) begin
                m_run   = 0;
                m_level = ~old;
                if (old == 0) begin
                    m_press = 1;
                    m_count = (m_count + 1) % (1 << PW);
                end else begin
                    m_rel = 1;
                end
            end
            if (old == 0 || commit) begin
                m_hold = 0;
            end else if (m_hold < L) begin
                m_hold = m_hold + 1;
`ifdef BTN_LONG_PRESS_EN
                m_long = (m_hold == L);
`endif
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock; outputs compared on the falling edge, away from the sampling edge.
    task automatic step();
        @(posedge clk_raw);
        @(negedge clk_raw);
        check("hi.level", 32'(hi_level), 32'(m_level));
        check("hi.press", 32'(hi_press), 32'(m_press));
        check("hi.rel",   32'(hi_rel),   32'(m_rel));
        check("hi.long",  32'(hi_long),  32'(m_long));
        check("hi.count", 32'(hi_count), 32'(m_count));
        check("lo.level", 32'(lo_level), 32'(m_level));
        check("lo.press", 32'(lo_press), 32'(m_press));
        check("lo.rel",   32'(lo_rel),   32'(m_rel));
        check("lo.long",  32'(lo_long),  32'(m_long));
        check("lo.count", 32'(lo_count), 32'(m_count));
        check("strobe_excl", 32'(hi_press & hi_rel), 32'd0);
    endtask

    task automatic hold_pin(input logic v, input int n);
        btn_pin = v;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic v, input int n);
        rst_n = 1'b0;
        btn_pin = v;
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
    endtask

    int k, ip, il, nlong;
    logic [PW-1:0] exp_seq [5];

    initial begin
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;

        // Reset held 3 cycles with the pin pressed: everything stays at zero.
        do_reset(1'b1, 3);
        check("rst.level", 32'(hi_level), 32'd0);
        check("rst.press", 32'(hi_press), 32'd0);
        check("rst.count", 32'(hi_count), 32'd0);

        // Press latency: capture at edge 1, commit at edge D+3.
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            step();
            if (hi_press) k = i;
        end
        check("press_latency", k, D + 3);
        check("first_count", 32'(hi_count), 32'd1);
        hold_pin(1'b1, 4);

        // Release latency counted from the first edge that sees the low pin.
        btn_pin = 1'b0;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            step();
            if (hi_rel) k = i;
        end
        check("release_latency", k, D + 3);
        check("released_level", 32'(hi_level), 32'd0);
        hold_pin(1'b0, 4);

        // Bounce: never D+1 agreeing samples, so nothing commits.
        hold_pin(1'b1, 3); hold_pin(1'b0, 1); hold_pin(1'b1, 2); hold_pin(1'b0, 10);
        check("bounce_count", 32'(hi_count), 32'd1);

        // Five full press/release cycles from reset: count wraps at 2^PW.
        do_reset(1'b0, 2);
        for (int c = 0; c < 5; c++) begin
            hold_pin(1'b1, 10);
            check("wrap_count", 32'(hi_count), 32'(exp_seq[c]));
            hold_pin(1'b0, 10);
        end

        // Long hold with a one-cycle release glitch after the press commit.
        ip = -1; il = -1; nlong = 0;
        for (int i = 0; i < 52; i++) begin
            btn_pin = (i < 40 && i != 14) ? 1'b1 : 1'b0;
            step();
            if (hi_press && ip < 0) ip = i;
            if (hi_long) begin
                nlong++;
                if (il < 0) il = i;
            end
        end
`ifdef BTN_LONG_PRESS_EN
        check("long_count", nlong, 1);
        check("long_delay", il - ip, L);
`else
        check("long_count", nlong, 0);
`endif

        // Reset while pressed, then a fresh debounce must fire press again.
        hold_pin(1'b1, 12);
        do_reset(1'b1, 2);
        hold_pin(1'b1, 12);

        // Randomised segments: short bounces, long holds, occasional reset.
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 2);
            end else if ($urandom_range(0, 2) == 0) begin
                hold_pin(1'($urandom_range(0, 1)), $urandom_range(1, D));
            end else begin
                hold_pin(1'($urandom_range(0, 1)), $urandom_range(D + 1, 30));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
